// File: rtl/rotate_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rotate_phase_ctrl_pkg
// Purpose  : Shared constants and state encoding for the rotate phase
//            sequencer. Phase values use the same scaling as the rotate
//            ATAN LUT (PI scaled by 2^9).
// Revision : 1.0 - initial release
// ============================================================================
package rotate_phase_ctrl_pkg;

  localparam int ROT_PI     = 1608;
  localparam int ROT_TWO_PI = 2 * ROT_PI;
  localparam int ROT_PI_2   = ROT_PI / 2;
  localparam int ROT_PI_4   = ROT_PI / 4;
  localparam int ROT_PI_3_4 = (3 * ROT_PI) / 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rotate_phase_ctrl_phase_wrap_add.sv
`default_nettype none
// ============================================================================
// Module   : phase_wrap_add
// Purpose  : Combinational phase adder with a single [-PI, PI] wrap, plus an
//            increment clamp to [-PI, PI]. With both operands inside
//            [-PI, PI] one wrap correction always lands back in range.
// Ports    : acc_in      - current phase (signed, in range)
//            inc_in      - increment to add (signed, already clamped)
//            raw_inc     - unclamped increment to be clamped
//            sum_out     - wrapped acc_in + inc_in
//            clamped_out - raw_inc clamped to [-PI_VAL, PI_VAL]
// Revision : 1.0 - initial release
// ============================================================================
module phase_wrap_add
  import rotate_phase_ctrl_pkg::*;
#(
  parameter int PI_VAL = ROT_PI
) (
  input  logic signed [31:0] acc_in,
  input  logic signed [31:0] inc_in,
  input  logic signed [31:0] raw_inc,
  output logic signed [31:0] sum_out,
  output logic signed [31:0] clamped_out
);

  localparam logic signed [32:0] PI33     = 33'(PI_VAL);
  localparam logic signed [32:0] NEG_PI33 = 33'(-PI_VAL);
  localparam logic signed [32:0] TWO_PI33 = 33'(2 * PI_VAL);
  localparam logic signed [31:0] PI32     = 32'(PI_VAL);
  localparam logic signed [31:0] NEG_PI32 = 32'(-PI_VAL);

  logic signed [32:0] sum33;

  // 33-bit sum so the pre-wrap value never overflows.
  always_comb begin
    sum33 = {acc_in[31], acc_in} + {inc_in[31], inc_in};
    // Exactly +/-PI is legal and left alone.
    if (sum33 > PI33) begin
      sum_out = 32'(sum33 - TWO_PI33);
    end else if (sum33 < NEG_PI33) begin
      sum_out = 32'(sum33 + TWO_PI33);
    end else begin
      sum_out = 32'(sum33);
    end
  end

  always_comb begin
    if (raw_inc > PI32) begin
      clamped_out = PI32;
    end else if (raw_inc < NEG_PI32) begin
      clamped_out = NEG_PI32;
    end else begin
      clamped_out = raw_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rotate_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotate_phase_ctrl
// Purpose  : Phase sequencer (NCO) feeding the rotate datapath for per-sample
//            CFO correction. Accumulates a clamped signed increment, wraps to
//            [-PI, PI] and emits the phase aligned with each I/Q sample
//            (1-cycle latency).
// Ports    : clock, reset      - clock, synchronous active-high reset
//            enable            - global clock enable (all registers hold)
//            start/stop        - pulses: restart into RUN / return to IDLE
//            freeze            - level: hold accumulator, samples still flow
//            phase_inc         - signed per-sample increment
//            update_stb        - pulse: reload increment while running
//            in_i/in_q, input_strobe     - input sample
//            out_i/out_q, phase, output_strobe - sample + phase to rotate
//            busy              - high in RUN or HOLD
//            sample_cnt        - samples processed since start (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module rotate_phase_ctrl
  import rotate_phase_ctrl_pkg::*;
#(
  parameter int PI_VAL = ROT_PI,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic                stop,
  input  logic                freeze,
  input  logic signed [31:0]  phase_inc,
  input  logic                update_stb,
  input  logic [15:0]         in_i,
  input  logic [15:0]         in_q,
  input  logic                input_strobe,
  output logic [15:0]         out_i,
  output logic [15:0]         out_q,
  output logic signed [31:0]  phase,
  output logic                output_strobe,
  output logic                busy,
  output logic [CNT_W-1:0]    sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic signed [31:0]        acc_q, acc_d;
  logic signed [31:0]        inc_q, inc_d;
  logic [15:0]               out_i_q, out_i_d;
  logic [15:0]               out_q_q, out_q_d;
  logic signed [31:0]        phase_q, phase_d;
  logic                      stb_q, stb_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [31:0]        add_a, add_b, add_sum, inc_clamped;

  // On start the adder computes 0 + clamp(phase_inc), so a strobe in the
  // start cycle leaves acc ready for the second sample.
  assign add_a = start ? 32'sd0 : acc_q;
  assign add_b = start ? inc_clamped : inc_q;

  phase_wrap_add #(
    .PI_VAL (PI_VAL)
  ) u_wrap (
    .acc_in      (add_a),
    .inc_in      (add_b),
    .raw_inc     (phase_inc),
    .sum_out     (add_sum),
    .clamped_out (inc_clamped)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      phase_q <= '0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
      phase_q <= phase_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    out_i_d = out_i_q;
    out_q_d = out_q_q;
    phase_d = phase_q;
    stb_d   = 1'b0;
    cnt_d   = cnt_q;

    if (enable) begin
      if (input_strobe) begin
        out_i_d = in_i;
        out_q_d = in_q;
        stb_d   = 1'b1;
      end

      if (start) begin
        // start wins over stop and freeze; start+stop restarts into RUN.
        state_d = ST_RUN;
        inc_d   = inc_clamped;
        acc_d   = '0;
        cnt_d   = '0;
        if (input_strobe) begin
          phase_d = '0;
          acc_d   = add_sum;
          cnt_d   = CNT_ONE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (input_strobe) begin
              phase_d = '0;
            end
          end
          ST_RUN, ST_HOLD: begin
            if (input_strobe) begin
              phase_d = acc_q;
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_ONE;
              end
              // freeze is a level: it holds acc on the very strobe it is
              // seen with, and releasing it advances acc on that strobe.
              if (!freeze) begin
                acc_d = add_sum;
              end
            end
            // New increment applies from the next strobe onward.
            if (update_stb) begin
              inc_d = inc_clamped;
            end
            if (stop) begin
              state_d = ST_IDLE;
              acc_d   = '0;
            end else if (freeze) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_RUN;
            end
          end
          default: begin
            state_d = ST_IDLE;
            acc_d   = '0;
          end
        endcase
      end
    end
  end

  assign out_i         = out_i_q;
  assign out_q         = out_q_q;
  assign phase         = phase_q;
  assign output_strobe = stb_q;
  assign busy          = (state_q != ST_IDLE);
  assign sample_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rotate_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_phase_ctrl
// Purpose  : Directed self-checking bench for rotate_phase_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_phase_ctrl;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               start;
  logic               stop;
  logic               freeze;
  logic signed [31:0] phase_inc;
  logic               update_stb;
  logic [15:0]        in_i;
  logic [15:0]        in_q;
  logic               input_strobe;
  logic [15:0]        out_i;
  logic [15:0]        out_q;
  logic signed [31:0] phase;
  logic               output_strobe;
  logic               busy;
  logic [15:0]        sample_cnt;

  int n_total = 0;
  int n_pass  = 0;

  rotate_phase_ctrl #(
    .PI_VAL (1608),
    .CNT_W  (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .freeze        (freeze),
    .phase_inc     (phase_inc),
    .update_stb    (update_stb),
    .in_i          (in_i),
    .in_q          (in_q),
    .input_strobe  (input_strobe),
    .out_i         (out_i),
    .out_q         (out_q),
    .phase         (phase),
    .output_strobe (output_strobe),
    .busy          (busy),
    .sample_cnt    (sample_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at the edge, outputs
  // are examined 1 time unit later; pulse inputs are then cleared.
  task automatic tick();
    @(posedge clock);
    #1;
    start        = 1'b0;
    stop         = 1'b0;
    update_stb   = 1'b0;
    input_strobe = 1'b0;
  endtask

  task automatic strobe_chk(input string tag, input int exp_phase);
    input_strobe = 1'b1;
    tick();
    check({tag, "_stb"}, 32'(output_strobe), 32'd1);
    check({tag, "_phase"}, phase, exp_phase);
  endtask

  int exp_pos [6] = '{0, 1000, -1216, -216, 784, -1432};
  int exp_neg [3] = '{0, -1000, 1216};
  int exp_clp [4] = '{0, 1608, 0, 1608};

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    freeze       = 1'b0;
    phase_inc    = '0;
    update_stb   = 1'b0;
    in_i         = '0;
    in_q         = '0;
    input_strobe = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_phase", phase, 0);
    check("rst_stb", 32'(output_strobe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(sample_cnt), 0);
    check("rst_out_i", 32'(out_i), 0);
    reset = 1'b0;
    tick();

    // IDLE pass-through
    in_i = 16'h0100;
    in_q = 16'hFF00;
    for (int k = 0; k < 5; k++) begin
      strobe_chk("idle", 0);
      check("idle_out_i", 32'(out_i), 32'h0100);
    end
    check("idle_out_q", 32'(out_q), 32'hFF00);
    tick();
    check("idle_stb_low", 32'(output_strobe), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_cnt", 32'(sample_cnt), 0);

    // Linear ramp
    phase_inc = 100;
    start     = 1'b1;
    tick();
    check("ramp_busy", 32'(busy), 1);
    check("ramp_cnt0", 32'(sample_cnt), 0);
    for (int k = 0; k < 10; k++) strobe_chk("ramp", 100 * k);
    check("ramp_cnt", 32'(sample_cnt), 10);

    // Positive wrap
    phase_inc = 1000;
    start     = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) strobe_chk("poswrap", exp_pos[k]);

    // Negative wrap
    phase_inc = -1000;
    start     = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) strobe_chk("negwrap", exp_neg[k]);

    // Clamp and exact +PI boundary
    phase_inc = 5000;
    start     = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) strobe_chk("clamp", exp_clp[k]);

    // Strobe in the start cycle counts as sample 1 with phase 0
    phase_inc    = 100;
    start        = 1'b1;
    input_strobe = 1'b1;
    tick();
    check("startstb_phase", phase, 0);
    check("startstb_cnt", 32'(sample_cnt), 1);
    strobe_chk("ramp2", 100);
    strobe_chk("ramp2", 200);

    // Freeze holds the accumulator
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) strobe_chk("freeze", 300);
    check("freeze_busy", 32'(busy), 1);
    check("freeze_cnt", 32'(sample_cnt), 6);

    // Release freeze with update in the same strobe cycle
    freeze     = 1'b0;
    update_stb = 1'b1;
    phase_inc  = 50;
    strobe_chk("upd_same", 300);
    strobe_chk("upd", 400);
    strobe_chk("upd", 450);
    in_i = 16'h1234;
    strobe_chk("upd", 500);

    // Enable low: everything holds, strobe drops
    enable       = 1'b0;
    in_i         = 16'h7777;
    input_strobe = 1'b1;
    tick();
    check("en_stb", 32'(output_strobe), 0);
    check("en_phase", phase, 500);
    check("en_out_i", 32'(out_i), 32'h1234);
    check("en_cnt", 32'(sample_cnt), 10);
    enable = 1'b1;
    strobe_chk("en_resume", 550);

    // start and stop together restart into RUN with acc 0
    phase_inc = 200;
    start     = 1'b1;
    stop      = 1'b1;
    tick();
    check("startstop_busy", 32'(busy), 1);
    strobe_chk("startstop", 0);
    strobe_chk("startstop", 200);

    // stop returns to IDLE, next sample has phase 0, count holds
    stop = 1'b1;
    tick();
    check("stop_busy", 32'(busy), 0);
    strobe_chk("stop", 0);
    check("stop_cnt", 32'(sample_cnt), 2);

    // Reset in the middle of RUN
    phase_inc = 100;
    start     = 1'b1;
    tick();
    strobe_chk("prerst", 0);
    strobe_chk("prerst", 100);
    reset        = 1'b1;
    input_strobe = 1'b1;
    tick();
    check("midrst_phase", phase, 0);
    check("midrst_stb", 32'(output_strobe), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cnt", 32'(sample_cnt), 0);
    check("midrst_out_i", 32'(out_i), 0);
    reset = 1'b0;
    tick();
    strobe_chk("postrst", 0);
    check("postrst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
